flow_quant_sched: RTL and testbench
===================================

# flow_quant_sched

Quantization scheduler in front of the `flow_mult` multiplier in the JPEG flow-math chain. It tracks the coefficient position inside each 8x8 block and the block index inside each MCU. From that position it looks up per-lane quantization multipliers in programmable tables. It forwards data, multipliers and framing, aligned and one cycle registered, to the multiplier inputs. It also checks block framing and resynchronises on errors.

## Interface
Parameters:
- `N`, 2, lanes per beat; legal values 1, 2, 4, 8 (must divide 64)
- `MCU_Y`, 4, luma blocks per MCU; followed by 2 chroma blocks (Cb, Cr)

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `en` in 1: global enable; a beat is accepted only when `in_valid & en`
- `cfg_we` in 1: table write strobe
- `cfg_table` in 1: 0 = luma table, 1 = chroma table
- `cfg_addr` in 6: coefficient index 0..63
- `cfg_data` in 10: unsigned multiplier value
- `in_valid` in 1: input beat valid
- `in_data` in N×16: signed coefficients
- `in_sob` / `in_eob` / `in_sof` in 1 each: start of block, end of block, start of frame
- `out_valid` out 1: output beat valid
- `out_data` out N×16: registered copy of `in_data`
- `out_mult` out N×10: per-lane multiplier
- `out_sob` / `out_eob` / `out_sof` out 1 each: registered framing
- `err` out 1: sticky framing error

## Operation
- Counters:
  - `pos` counts 0..64/N−1 and advances on each accepted beat.
  - `blk` counts 0..MCU_Y+1 and advances on each accepted `in_eob` beat. It wraps from MCU_Y+1 to 0.
- Lane `i` of a beat at `pos` p carries coefficient index p·N+i. `out_mult[i]` = table[sel][p·N+i].
- Table select: `sel` = luma when `blk` < MCU_Y, else chroma.
- Tables are two arrays of 64×10 registers. Every entry resets to 10'd1.
  - A write takes effect the cycle after `cfg_we`.
  - A same-cycle read of the written entry returns the old value.
  - Writes are accepted in any state.
- FSM states: IDLE, RUN.
- IDLE:
  - Accepted beats are dropped (`out_valid`=0).
  - A beat with `in_sof & in_sob` moves the FSM to RUN. That beat is forwarded with `pos`=0 and `blk`=0.
- RUN:
  - A beat with `in_sof` (which must also carry `in_sob`) restarts `pos`=0 and `blk`=0.
  - Check: `in_sob` must equal (`pos`==0), and `in_eob` must equal (`pos`==64/N−1).
  - On any mismatch, or `in_sof` without `in_sob`:
    - the beat is dropped;
    - `err` is set;
    - the FSM goes to IDLE, and `pos` and `blk` clear.
- `err` clears only on the beat that re-enters RUN, or on reset.
- Simultaneous cfg write and lookup of the same entry: the old value is used (see above).

## Timing
- Latency is 1 cycle from an accepted input beat to the output beat.
- `out_valid` <= `in_valid & en & forward` every cycle, so it is low in any cycle with `en`=0.
- `out_data`, `out_mult` and the framing outputs update only on forwarded beats; otherwise they hold.
- The framing outputs are gated by the forwarded valid, so they are never high while `out_valid` is 0.
- Reset values:
  - all outputs 0;
  - FSM IDLE;
  - `pos`=0, `blk`=0;
  - tables all 1.
- Reset mid-block discards the block. The next frame must start with `in_sof`.
- There is no backpressure. The downstream multiplier accepts every `out_valid` beat.

## Configuration
- `FLOW_QUANT_CHROMA_EN` defined:
  - two tables;
  - `blk` counter and luma/chroma select as above.
- Not defined:
  - single luma table; `cfg_table` is ignored;
  - `blk` counter removed; every block uses the luma table;
  - `pos` checking and the FSM are unchanged.

## Test plan
- Write luma[k]=k+1 and chroma[k]=100+k. Send one frame, N=2, MCU_Y=4, 6 blocks of 32 beats.
  - Expected: blocks 0–3 beat 5 give `out_mult`={12,11}; block 4 beat 5 gives {111,110}.
  - Expected: `out_valid` one cycle after each input beat; `err`=0.
- Send 8 beats without `in_sof` after reset.
  - Expected: no `out_valid`; `err`=1.
  - Then a `sof`+`sob` beat: forwarded, `err`=0.
- Assert `in_eob` on beat 30 of a block.
  - Expected: that beat is dropped, `err`=1, FSM in IDLE; following beats are dropped until `in_sof`.
- Write luma[4]=77 in the same cycle as a beat at `pos` 2 (lanes 4, 5).
  - Expected: old value 1 on lane 0.
  - Next block at `pos` 2: 77.
- Toggle `en`=0 for 3 cycles mid-block with `in_valid`=1.
  - Expected: `out_valid`=0 for those cycles; `pos` frozen; the block completes with a correct `out_eob`.
- Assert `rst_n` mid-block.
  - Expected: all outputs 0 and tables reset to 1.
  - Expected: the next non-sof beat is dropped and `err`=1.

Source files
------------

// File: rtl/flow_quant_sched_if.sv
// flow_quant_sched_if: beat bus into and out of the quantization scheduler
// Ports: in_* carry upstream coefficient beats with framing; out_* carry the
// registered beat, per-lane multipliers and framing towards flow_mult.
interface flow_quant_sched_if #(
  parameter int N = 2
);
  logic            in_valid;
  logic [N*16-1:0] in_data;
  logic            in_sob;
  logic            in_eob;
  logic            in_sof;
  logic            out_valid;
  logic [N*16-1:0] out_data;
  logic [N*10-1:0] out_mult;
  logic            out_sob;
  logic            out_eob;
  logic            out_sof;
  modport master (
    output in_valid, in_data, in_sob, in_eob, in_sof,
    input  out_valid, out_data, out_mult, out_sob, out_eob, out_sof
  );
  modport slave (
    input  in_valid, in_data, in_sob, in_eob, in_sof,
    output out_valid, out_data, out_mult, out_sob, out_eob, out_sof
  );
endinterface

// File: rtl/flow_quant_sched.sv
// flow_quant_sched: per-lane quantization multiplier scheduler in front of flow_mult
// Ports: clk; rst_n async active-low; en gates beat acceptance; cfg_we/cfg_table/
// cfg_addr/cfg_data write the multiplier tables; bus (slave) carries input beats and
// the one-cycle registered output beats; err is the sticky framing error.
// Define FLOW_QUANT_CHROMA_EN for a separate chroma table selected by MCU block index.
module flow_quant_sched #(
  parameter int N     = 2,
  parameter int MCU_Y = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_we,
  input  logic              cfg_table,
  input  logic [5:0]        cfg_addr,
  input  logic [9:0]        cfg_data,
  flow_quant_sched_if.slave bus,
  output logic              err
);
  localparam int BEATS = 64 / N;
  localparam int PW = $clog2(BEATS);
  localparam logic [PW-1:0] LAST = PW'(BEATS - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic acc, start, bad, fwd, luma_we;
  logic [PW-1:0] pos_q, pos_d, pos_e;
  logic err_q, err_d, valid_q, valid_d;
  logic [N*16-1:0] data_q, data_d;
  logic [N*10-1:0] mult_q, mult_d;
  logic [2:0] fr_q, fr_d;
  logic [5:0] idx;
  logic [9:0] row [64];
  logic [9:0] luma_q [64];
  logic [9:0] luma_d [64];
`ifdef FLOW_QUANT_CHROMA_EN
  localparam int BW = $clog2(MCU_Y + 2);
  localparam logic [BW-1:0] BLK_LAST = BW'(MCU_Y + 1);
  logic [BW-1:0] blk_q, blk_d, blk_e;
  logic [9:0] chroma_q [64];
  logic [9:0] chroma_d [64];
  assign luma_we = cfg_we & ~cfg_table;
  // Block index follows the same restart/clear rules as pos; it steps on forwarded eob beats.
  always_comb begin
    blk_e = bus.in_sof ? '0 : blk_q;
    blk_d = fwd ? (bus.in_eob ? (blk_e == BLK_LAST ? '0 : blk_e + 1'b1) : blk_e) : acc ? '0 : blk_q;
    chroma_d = chroma_q;
    if (cfg_we && cfg_table) chroma_d[cfg_addr] = cfg_data;
    for (int k = 0; k < 64; k++) row[k] = (blk_e >= BW'(MCU_Y)) ? chroma_q[k] : luma_q[k];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      blk_q <= '0;
      for (int k = 0; k < 64; k++) chroma_q[k] <= 10'd1;
    end else begin
      blk_q <= blk_d;
      chroma_q <= chroma_d;
    end
`else
  logic unused_cfg_table;
  assign unused_cfg_table = cfg_table;
  assign luma_we = cfg_we;
  always_comb for (int k = 0; k < 64; k++) row[k] = luma_q[k];
`endif
  // A sof beat restarts the block position before it is checked, so sof+sob always passes.
  // Any accepted beat that is not forwarded is a framing violation: drop it, go IDLE, clear counters.
  always_comb begin
    acc = bus.in_valid & en;
    start = bus.in_sof & bus.in_sob;
    pos_e = bus.in_sof ? '0 : pos_q;
    bad = (bus.in_sof & ~bus.in_sob) | (bus.in_sob != (pos_e == '0)) | (bus.in_eob != (pos_e == LAST));
    fwd = acc & (state_q == IDLE ? start : ~bad);
    state_d = fwd ? RUN : acc ? IDLE : state_q;
    err_d = fwd ? 1'b0 : acc ? 1'b1 : err_q;
    pos_d = fwd ? (pos_e == LAST ? '0 : pos_e + 1'b1) : acc ? '0 : pos_q;
    valid_d = fwd;
    data_d = fwd ? bus.in_data : data_q;
    fr_d = fwd ? {bus.in_sob, bus.in_eob, bus.in_sof} : fr_q;
    idx = '0;
    mult_d = mult_q;
    for (int i = 0; i < N; i++) begin
      idx = 6'(int'(pos_e) * N + i);
      mult_d[i*10 +: 10] = fwd ? row[idx] : mult_q[i*10 +: 10];
    end
    luma_d = luma_q;
    if (luma_we) luma_d[cfg_addr] = cfg_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pos_q <= '0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
      mult_q <= '0;
      fr_q <= '0;
      for (int k = 0; k < 64; k++) luma_q[k] <= 10'd1;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      err_q <= err_d;
      valid_q <= valid_d;
      data_q <= data_d;
      mult_q <= mult_d;
      fr_q <= fr_d;
      luma_q <= luma_d;
    end
  assign bus.out_valid = valid_q;
  assign bus.out_data = data_q;
  assign bus.out_mult = mult_q;
  assign {bus.out_sob, bus.out_eob, bus.out_sof} = fr_q & {3{valid_q}};
  assign err = err_q;
endmodule

// File: tb/tb_flow_quant_sched.sv
// tb_flow_quant_sched: directed scoreboard bench for flow_quant_sched
module tb_flow_quant_sched;
  localparam int N = 2;
  localparam int MCU_Y = 4;
  localparam int BEATS = 64 / N;
  localparam int DW = N * 16;
`ifdef FLOW_QUANT_CHROMA_EN
  localparam bit CHROMA = 1'b1;
`else
  localparam bit CHROMA = 1'b0;
`endif
  typedef struct packed {
    logic [N*16-1:0] data;
    logic [N*10-1:0] mult;
    logic [2:0]      fr;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic cfg_we = 1'b0;
  logic cfg_table = 1'b0;
  logic [5:0] cfg_addr = '0;
  logic [9:0] cfg_data = '0;
  logic err;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [9:0] lm [64];
  logic [9:0] cm [64];
  logic pend = 1'b0;
  logic pend_tbl = 1'b0;
  logic [5:0] pend_addr = '0;
  logic [9:0] pend_data = '0;
  flow_quant_sched_if #(.N(N)) bus ();
  flow_quant_sched #(.N(N), .MCU_Y(MCU_Y)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .cfg_we(cfg_we),
    .cfg_table(cfg_table),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .bus(bus),
    .err(err)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [N*10-1:0] model_mult(input int p, input int b);
    logic [N*10-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++)
      m[i*10 +: 10] = (CHROMA && b >= MCU_Y) ? cm[p*N+i] : lm[p*N+i];
    return m;
  endfunction

  task automatic cfg_set(input logic t, input int a, input int d);
    cfg_we = 1'b1;
    cfg_table = t;
    cfg_addr = 6'(a);
    cfg_data = 10'(d);
    pend = 1'b1;
    pend_tbl = t;
    pend_addr = 6'(a);
    pend_data = 10'(d);
  endtask

  // One clock of stimulus; a beat the model expects forwarded is pushed now and popped after the edge.
  task automatic step(input logic v, input logic e, input logic sob, input logic eob, input logic sof,
                      input int p, input int b, input logic fwd);
    exp_t x;
    logic pushed;
    bus.in_valid = v;
    en = e;
    bus.in_sob = sob;
    bus.in_eob = eob;
    bus.in_sof = sof;
    bus.in_data = DW'($urandom);
    pushed = v & e & fwd;
    if (pushed) begin
      x.data = bus.in_data;
      x.mult = model_mult(p, b);
      x.fr = {sob, eob, sof};
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    if (pend) begin
      if (pend_tbl && CHROMA) cm[pend_addr] = pend_data;
      else lm[pend_addr] = pend_data;
      pend = 1'b0;
      cfg_we = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk("out_valid", 64'(bus.out_valid), 64'(pushed));
    if (bus.out_valid) begin
      chk("sb_level", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(x.data));
        chk("out_mult", 64'(bus.out_mult), 64'(x.mult));
        chk("out_framing", 64'({bus.out_sob, bus.out_eob, bus.out_sof}), 64'(x.fr));
      end
    end else begin
      chk("idle_framing", 64'({bus.out_sob, bus.out_eob, bus.out_sof}), 64'(0));
    end
  endtask

  task automatic beat(input int p, input int b, input logic sof);
    step(1'b1, 1'b1, p == 0, p == BEATS - 1, sof, p, b, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    cfg_we = 1'b0;
    pend = 1'b0;
    #1;
    chk("sb_drain", 64'(sb.size()), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_mult", 64'(bus.out_mult), 64'(0));
    chk("rst_framing", 64'({bus.out_sob, bus.out_eob, bus.out_sof}), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    sb.delete();
    for (int k = 0; k < 64; k++) begin
      lm[k] = 10'd1;
      cm[k] = 10'd1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_sob = 1'b0;
    bus.in_eob = 1'b0;
    bus.in_sof = 1'b0;
    do_reset();
    // Chroma first so that a single-table build ends with luma[k]=k+1.
    for (int k = 0; k < 64; k++) begin
      cfg_set(1'b1, k, 100 + k);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    end
    for (int k = 0; k < 64; k++) begin
      cfg_set(1'b0, k, k + 1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    end
    for (int b = 0; b < MCU_Y + 2; b++)
      for (int p = 0; p < BEATS; p++) begin
        beat(p, b, b == 0 && p == 0);
        if (p == 5)
          chk("beat5_mult", 64'(bus.out_mult),
              (CHROMA && b >= MCU_Y) ? 64'({10'd111, 10'd110}) : 64'({10'd12, 10'd11}));
      end
    chk("err_frame", 64'(err), 64'(0));
    // Beats without sof after reset are dropped and flag an error.
    do_reset();
    for (int p = 0; p < 8; p++) step(1'b1, 1'b1, p == 0, 1'b0, 1'b0, p, 0, 1'b0);
    chk("err_nosof", 64'(err), 64'(1));
    beat(0, 0, 1'b1);
    chk("err_clear", 64'(err), 64'(0));
    for (int p = 1; p < BEATS; p++) beat(p, 0, 1'b0);
    // Early eob drops the beat and parks in IDLE until the next sof.
    for (int p = 0; p < 30; p++) beat(p, 0, p == 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 30, 0, 1'b0);
    chk("err_eob30", 64'(err), 64'(1));
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 31, 0, 1'b0);
    for (int p = 0; p < 4; p++) step(1'b1, 1'b1, p == 0, 1'b0, 1'b0, p, 0, 1'b0);
    chk("err_held", 64'(err), 64'(1));
    for (int p = 0; p < BEATS; p++) beat(p, 0, p == 0);
    chk("err_recover", 64'(err), 64'(0));
    // Table write racing a lookup of the same entry.
    for (int p = 0; p < BEATS; p++) begin
      if (p == 2) cfg_set(1'b0, 4, 77);
      beat(p, 1, 1'b0);
      if (p == 2) chk("cfg_old", 64'(bus.out_mult[9:0]), 64'(1));
    end
    for (int p = 0; p < BEATS; p++) begin
      beat(p, 2, 1'b0);
      if (p == 2) chk("cfg_new", 64'(bus.out_mult[9:0]), 64'(77));
    end
    // Enable low for three cycles mid-block with valid held high.
    for (int p = 0; p < BEATS; p++) begin
      if (p == 10)
        for (int s = 0; s < 3; s++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, p, 3, 1'b0);
      beat(p, 3, 1'b0);
    end
    chk("eob_after_stall", 64'(bus.out_eob), 64'(1));
    chk("err_stall", 64'(err), 64'(0));
    // Reset mid-block.
    for (int p = 0; p < 15; p++) beat(p, 4, 1'b0);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 15, 0, 1'b0);
    chk("err_after_rst", 64'(err), 64'(1));
    for (int p = 0; p < BEATS; p++) begin
      beat(p, 0, p == 0);
      if (p == 2) chk("tbl_reset", 64'(bus.out_mult[9:0]), 64'(1));
    end
    chk("err_final", 64'(err), 64'(0));
    chk("sb_final", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
